// File: rtl/mw_eeprom_pkg.sv
// mw_eeprom_pkg: Microwire EEPROM mode/opcode encodings, controller states and frame-length helper
package mw_eeprom_pkg;
    localparam logic [2:0] MODE_EWEN  = 3'd0;
    localparam logic [2:0] MODE_WRITE = 3'd1;
    localparam logic [2:0] MODE_READ  = 3'd2;
    localparam logic [2:0] MODE_EWDS  = 3'd3;
    localparam logic [2:0] MODE_ERASE = 3'd4;

    localparam logic [1:0] OP_CTRL  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_ERASE = 2'b11;

    typedef enum logic [1:0] {IDLE, SHIFT, TCS, POLL} state_t;

    function automatic int frame_len(input logic [2:0] mode, input int aw, input int dw);
        return (mode == MODE_WRITE || mode == MODE_READ) ? 3 + aw + dw : 3 + aw;
    endfunction

    function automatic logic [1:0] opcode(input logic [2:0] mode);
        return mode == MODE_WRITE ? OP_WRITE :
               mode == MODE_READ  ? OP_READ  :
               mode == MODE_ERASE ? OP_ERASE : OP_CTRL;
    endfunction
endpackage

// File: rtl/mw_bit_timer.sv
// mw_bit_timer: divides clk into Microwire bit periods, sk low for the first half and high for the second
module mw_bit_timer #(
    parameter int CLK_DIV = 100
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic bit_start,
    output logic sk_rise,
    output logic bit_end,
    output logic sk
);
    localparam int W = $clog2(CLK_DIV);
    localparam logic [W-1:0] HALF = W'(CLK_DIV / 2);
    localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || !en)
            cnt <= '0;
        else
            cnt <= cnt == LAST ? '0 : cnt + 1'b1;
    end

    assign bit_start = en && cnt == '0;
    assign sk_rise   = en && cnt == HALF;
    assign bit_end   = en && cnt == LAST;
    assign sk        = en && cnt >= HALF;
endmodule

// File: rtl/mw_eeprom_ctrl.sv
// mw_eeprom_ctrl: 93Cxx Microwire EEPROM controller; define MW_BUSY_TIMEOUT_EN to bound the ready/busy poll
module mw_eeprom_ctrl
    import mw_eeprom_pkg::*;
#(
    parameter int CLK_DIV = 100,
    parameter int ADDR_W  = 7,
    parameter int DATA_W  = 8,
    parameter int TCS_CYC = 100,
    parameter int BUSY_TO = 1000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [2:0]        mode,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              rdy,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_vld,
    output logic              err,
    output logic              cs,
    output logic              sk,
    output logic              mosi,
    input  logic              miso
);
    localparam int L  = 3 + ADDR_W + DATA_W;
    localparam int BW = $clog2(L + 1);
    localparam int TW = $clog2(TCS_CYC + 1);
    localparam logic [BW-1:0] CMD_BITS = BW'(3 + ADDR_W);
    localparam logic [TW-1:0] TCS_LAST = TW'(TCS_CYC - 1);
    localparam logic [ADDR_W-1:0] EWEN_A = {2'b11, {(ADDR_W - 2){1'b0}}};

    state_t            state, nxt;
    logic [2:0]        mode_q;
    logic [L-1:0]      sr;
    logic [DATA_W-1:0] rd_sr;
    logic [BW-1:0]     bit_cnt;
    logic [TW-1:0]     tcs_cnt;
    logic [ADDR_W-1:0] afield;
    logic [DATA_W-1:0] dfield;
    logic              miso_q, en, bit_start, sk_rise, bit_end, to_hit, accept, illegal;

    assign accept  = state == IDLE && start && mode <= MODE_ERASE;
    assign illegal = state == IDLE && start && mode > MODE_ERASE;
    assign afield  = mode == MODE_EWEN ? EWEN_A : mode == MODE_EWDS ? '0 : addr;
    assign dfield  = mode == MODE_WRITE ? wdata : '0;

    mw_bit_timer #(.CLK_DIV(CLK_DIV)) u_timer (
        .clk(clk), .rst_n(rst_n), .en(en),
        .bit_start(bit_start), .sk_rise(sk_rise), .bit_end(bit_end), .sk(sk)
    );

`ifdef MW_BUSY_TIMEOUT_EN
    localparam int OW = $clog2(BUSY_TO + 1);
    localparam logic [OW-1:0] BUSY_LAST = OW'(BUSY_TO - 1);
    logic [OW-1:0] busy_cnt;
    always_ff @(posedge clk) begin
        if (!rst_n || state != POLL)
            busy_cnt <= '0;
        else
            busy_cnt <= busy_cnt + 1'b1;
    end
    assign to_hit = state == POLL && busy_cnt == BUSY_LAST;
`else
    assign to_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = accept ? SHIFT : IDLE;
            SHIFT:   nxt = bit_end && bit_cnt == BW'(frame_len(mode_q, ADDR_W, DATA_W)) ? TCS : SHIFT;
            TCS:     nxt = tcs_cnt != TCS_LAST ? TCS :
                           (mode_q == MODE_WRITE || mode_q == MODE_ERASE) ? POLL : IDLE;
            POLL:    nxt = miso_q || to_hit ? IDLE : POLL;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        rdy  = state == IDLE;
        cs   = state == SHIFT || state == POLL;
        en   = state == SHIFT;
        mosi = en && sr[L-1];
    end

    // bit_cnt counts bits started, so during bit k (past its first cycle) it holds k+1
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q    <= '0;
            sr        <= '0;
            rd_sr     <= '0;
            bit_cnt   <= '0;
            tcs_cnt   <= '0;
            miso_q    <= 1'b0;
            rdata     <= '0;
            rdata_vld <= 1'b0;
            err       <= 1'b0;
        end else begin
            miso_q    <= miso;
            rdata_vld <= 1'b0;
            err       <= illegal || to_hit;
            tcs_cnt   <= state == TCS ? tcs_cnt + 1'b1 : '0;
            if (accept) begin
                mode_q  <= mode;
                sr      <= {1'b1, opcode(mode), afield, dfield};
                bit_cnt <= '0;
            end
            if (bit_start)
                bit_cnt <= bit_cnt + 1'b1;
            if (bit_end)
                sr <= sr << 1;
            if (sk_rise && mode_q == MODE_READ && bit_cnt > CMD_BITS)
                rd_sr <= {rd_sr[DATA_W-2:0], miso};
            if (state == TCS && nxt == IDLE && mode_q == MODE_READ) begin
                rdata     <= rd_sr;
                rdata_vld <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mw_eeprom_ctrl.sv
// tb_mw_eeprom_ctrl: scoreboard bench for mw_eeprom_ctrl with a 93Cxx EEPROM model
module tb_mw_eeprom_ctrl;
    localparam int TCS = 20;

    logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [2:0] mode = '0;
    logic [6:0] addr = '0;
    logic [7:0] wdata = '0, rdata;
    logic       rdy, rdata_vld, err, cs, sk, mosi, miso;
    logic       ready = 1'b0, rd_bit = 1'b0;
    logic [7:0] miso_data = '0;

    typedef struct {
        string       name;
        int          kind;
        int          len;
        logic [31:0] val;
    } exp_t;
    exp_t sbq[$];
    int n_cmp = 0, n_bad = 0;

    mw_eeprom_ctrl #(.CLK_DIV(4), .ADDR_W(7), .DATA_W(8), .TCS_CYC(TCS), .BUSY_TO(50)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .addr(addr), .wdata(wdata),
        .rdy(rdy), .rdata(rdata), .rdata_vld(rdata_vld), .err(err),
        .cs(cs), .sk(sk), .mosi(mosi), .miso(miso)
    );

    always #5 clk = ~clk;

    assign miso = ready | rd_bit;

    // EEPROM model: after the 10 command bits, present one data bit per sk falling edge
    int   m_n = 0;
    logic m_cs = 1'b0, m_sk = 1'b0;
    always @(negedge clk) begin
        if (cs && !m_cs) begin
            m_n    = 0;
            rd_bit = 1'b0;
        end
        if (cs && !sk && m_sk) begin
            m_n++;
            rd_bit = (m_n >= 10 && m_n < 18) ? miso_data[17 - m_n] : 1'b0;
        end
        m_cs = cs;
        m_sk = sk;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic push(input string name, input int kind, input int len, input logic [31:0] val);
        exp_t e;
        e.name = name; e.kind = kind; e.len = len; e.val = val;
        sbq.push_back(e);
    endtask

    task automatic emit(input int kind, input int len, input logic [31:0] val);
        exp_t e;
        n_cmp++;
        if (sbq.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_event: got kind=%0d len=%0d val=%0h expected nothing", kind, len, val);
        end else begin
            e = sbq.pop_front();
            if (e.kind != kind || e.len != len || e.val !== val) begin
                n_bad++;
                $display("FAIL %s: got kind=%0d len=%0d val=%0h expected kind=%0d len=%0d val=%0h",
                         e.name, kind, len, val, e.kind, e.len, e.val);
            end
        end
    endtask

    // monitor: kind 0 = frame on mosi, 1 = rdata_vld, 2 = err pulse
    initial begin
        int          nb = 0;
        logic [31:0] fv = '0;
        logic        p_sk = 1'b0, p_cs = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                nb = 0;
                fv = '0;
            end else begin
                if (cs && sk && !p_sk) begin
                    fv = {fv[30:0], mosi};
                    nb++;
                end
                if (!cs && p_cs && nb > 0) begin
                    emit(0, nb, fv);
                    nb = 0;
                    fv = '0;
                end
                if (rdata_vld) emit(1, 8, {24'd0, rdata});
                if (err) emit(2, 0, 0);
            end
            p_sk = sk;
            p_cs = cs;
        end
    end

    function automatic logic sel(input int w);
        return w == 0 ? cs : w == 1 ? rdy : err;
    endfunction

    task automatic wait_until(input int w, input logic lvl, input int limit, output int n);
        n = 0;
        while (sel(w) != lvl && n < limit) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic do_start(input logic [2:0] m, input logic [6:0] a, input logic [7:0] d);
        @(negedge clk);
        start = 1'b1; mode = m; addr = a; wdata = d;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        repeat (3) @(negedge clk);
        check("rst_rdy", rdy, 1);
        check("rst_cs", cs, 0);
        check("rst_sk", sk, 0);
        check("rst_mosi", mosi, 0);
        check("rst_rdata", rdata, 0);
        check("rst_rdata_vld", rdata_vld, 0);
        check("rst_err", err, 0);
        rst_n = 1'b1;

        // WRITE 0x15 <- 0xA5 with a 40-cycle busy period
        push("write_frame", 0, 18, 32'h295A5);
        do_start(3'd1, 7'h15, 8'hA5);
        wait_until(0, 1'b0, 200, n);  check("write_shift_cycles", n, 72);
        wait_until(0, 1'b1, 200, n);  check("write_tcs_cycles", n, TCS);
        repeat (39) @(negedge clk);
        check("write_poll_busy_rdy", rdy, 0);
        check("write_poll_cs", cs, 1);
        ready = 1'b1;
        wait_until(1, 1'b1, 100, n);  check("write_poll_exit", n, 2);
        ready = 1'b0;

        // READ 0x7F -> 0x3C
        miso_data = 8'h3C;
        push("read7f_frame", 0, 18, 32'h37F00);
        push("read7f_data", 1, 8, 32'h3C);
        do_start(3'd2, 7'h7F, 8'h00);
        wait_until(1, 1'b1, 500, n);  check("read_busy_cycles", n, 92);
        check("read_vld_at_idle", rdata_vld, 1);
        check("read_rdata", rdata, 8'h3C);
        @(negedge clk);
        check("read_vld_single", rdata_vld, 0);

        // EWEN then EWDS, no POLL
        push("ewen_frame", 0, 10, 32'h260);
        do_start(3'd0, 7'h00, 8'h00);
        wait_until(1, 1'b1, 500, n);  check("ewen_cycles", n, 60);
        push("ewds_frame", 0, 10, 32'h200);
        do_start(3'd3, 7'h00, 8'h00);
        wait_until(1, 1'b1, 500, n);  check("ewds_cycles", n, 60);

        // illegal mode
        push("illegal_err", 2, 0, 0);
        do_start(3'd6, 7'h11, 8'h22);
        check("illegal_err_pulse", err, 1);
        check("illegal_rdy", rdy, 1);
        check("illegal_cs", cs, 0);
        @(negedge clk);
        check("illegal_cs_later", cs, 0);

        // start during READ is ignored
        miso_data = 8'h81;
        push("read55_frame", 0, 18, 32'h35500);
        push("read55_data", 1, 8, 32'h81);
        do_start(3'd2, 7'h55, 8'h00);
        repeat (10) @(negedge clk);
        start = 1'b1; mode = 3'd1; addr = 7'h00; wdata = 8'hFF;
        @(negedge clk);
        start = 1'b0;
        wait_until(1, 1'b1, 500, n);  check("read_ignore_cycles", n, 81);
        check("read_ignore_rdata", rdata, 8'h81);
        repeat (5) @(negedge clk);
        check("read_ignore_no_frame", cs, 0);

        // reset during bit 9 of a WRITE
        miso_data = 8'h00;
        do_start(3'd1, 7'h15, 8'hA5);
        repeat (37) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_cs", cs, 0);
        check("abort_sk", sk, 0);
        check("abort_rdy", rdy, 1);
        check("abort_vld", rdata_vld, 0);
        check("abort_rdata", rdata, 0);
        miso_data = 8'hC3;
        push("read01_frame", 0, 18, 32'h30100);
        push("read01_data", 1, 8, 32'hC3);
        do_start(3'd2, 7'h01, 8'h00);
        wait_until(1, 1'b1, 500, n);  check("post_abort_read_cycles", n, 92);
        check("post_abort_rdata", rdata, 8'hC3);

        // ERASE with EEPROM stuck busy
        miso_data = 8'h00;
        push("erase_frame", 0, 10, 32'h3AA);
        do_start(3'd4, 7'h2A, 8'h00);
        wait_until(0, 1'b0, 200, n);  check("erase_shift_cycles", n, 40);
        wait_until(0, 1'b1, 200, n);  check("erase_tcs_cycles", n, TCS);
`ifdef MW_BUSY_TIMEOUT_EN
        push("timeout_err", 2, 0, 0);
        wait_until(1, 1'b1, 200, n);  check("timeout_cycles", n, 50);
        check("timeout_err_pulse", err, 1);
        check("timeout_cs", cs, 0);
`else
        wait_until(1, 1'b1, 1000, n); check("no_timeout_cycles", n, 1000);
        check("no_timeout_rdy", rdy, 0);
        ready = 1'b1;
        wait_until(1, 1'b1, 100, n);  check("late_ready_exit", n, 2);
        ready = 1'b0;
`endif
        repeat (5) @(negedge clk);
        check("scoreboard_drained", sbq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mw_eeprom_ctrl.md
Name: mw_eeprom_ctrl

Overview:
Parametrised Microwire serial-EEPROM controller (93Cxx family). It is the successor of the fixed 7-bit-address / 8-bit-data controller.
- Generalises clock divider, address width and data width.
- Adds EWDS and ERASE commands, ready/busy polling after program cycles, and error reporting.
- Sits between the user command logic and the EEPROM pins cs/sk/mosi/miso.

Parameters:
CLK_DIV, 100, clk cycles per sk period; even, ≥4 (100 MHz clk gives 1 MHz sk)
ADDR_W, 7, EEPROM address bits
DATA_W, 8, EEPROM data word bits
TCS_CYC, 100, clk cycles cs is held low between a frame and the busy poll or the return to idle
BUSY_TO, 1000000, clk cycles allowed in busy poll before timeout (used only with the optional feature)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
start  in  1  command request; accepted only when rdy=1
mode  in  3  0=EWEN 1=WRITE 2=READ 3=EWDS 4=ERASE; 5-7 illegal
addr  in  ADDR_W  word address
wdata  in  DATA_W  write data
rdy  out  1  controller idle and able to accept start
rdata  out  DATA_W  last read word
rdata_vld  out  1  one-cycle pulse when rdata is updated
err  out  1  one-cycle pulse on an illegal mode or a busy timeout
cs  out  1  chip select, active high
sk  out  1  serial clock
mosi  out  1  serial data to EEPROM
miso  in  1  serial data / ready-busy from EEPROM

Behaviour:
- Reset values (rst_n=0 at a clk edge): rdy=1, cs=0, sk=0, mosi=0, rdata=0, rdata_vld=0, err=0, state=IDLE, all counters 0. Reset mid-frame aborts immediately; no partial rdata_vld.
- Handshake: start is sampled only in IDLE with rdy=1. mode, addr and wdata are latched at the accept edge, and rdy drops at that same edge. start while rdy=0 is ignored.
- Illegal mode (5-7): no frame is sent, err=1 for one cycle, rdy stays 1.
- Frame, MSB first: start bit 1, 2-bit opcode, ADDR_W address field, then an optional data field.
  - EWEN: 1,00,11 followed by 0s.
  - EWDS: 1,00,00 followed by 0s.
  - WRITE: 1,01,addr,wdata.
  - READ: 1,10,addr, then DATA_W input bits.
  - ERASE: 1,11,addr.
- Frame length N:
  - EWEN, EWDS, ERASE: 3+ADDR_W.
  - WRITE, READ: 3+ADDR_W+DATA_W.
- States and transitions:
  - IDLE → SHIFT on accept.
  - SHIFT → TCS after N bit periods.
  - TCS → POLL for WRITE or ERASE, after TCS_CYC cycles.
  - TCS → IDLE for all other modes, after TCS_CYC cycles.
  - POLL → IDLE when the registered miso reads 1.
- Bit timing: each bit period is CLK_DIV cycles. sk=0 for the first CLK_DIV/2 cycles and 1 for the second half. mosi changes only at the start of a bit period. The last bit period ends with sk=0.
- cs: 1 in SHIFT and POLL, 0 elsewhere. cs rises at the accept edge.
- READ: miso is sampled at each sk rising edge of the final DATA_W bit periods. mosi=0 during those periods.
- READ completion: rdata updates and rdata_vld pulses at the TCS→IDLE edge. rdata then holds until the next READ.
- rdy returns to 1 at the edge entering IDLE. A new start may be accepted on the next cycle.
- POLL: sk=0, mosi=0, and miso is sampled every clk.

Optional Feature:
Macro MW_BUSY_TIMEOUT_EN.
- Defined: a POLL cycle counter runs. Reaching BUSY_TO cycles forces POLL → IDLE, pulses err for one cycle and drops cs.
- Undefined: POLL waits indefinitely for miso=1; err is driven only by illegal mode; no counter is synthesised.

Decomposition:
- Package mw_eeprom_pkg holds:
  - mode encoding constants (MODE_EWEN…MODE_ERASE);
  - 2-bit opcode constants;
  - state enum (IDLE, SHIFT, TCS, POLL);
  - helper function returning frame length from mode, ADDR_W and DATA_W.
- One sub-module, mw_bit_timer:
  - parametrised by CLK_DIV;
  - enable in;
  - strobes bit_start, sk_rise and bit_end;
  - sk level out.

Test Plan:
1. CLK_DIV=4, ADDR_W=7, DATA_W=8, mode=1, addr=0x15, wdata=0xA5; EEPROM model holds miso=0 for 40 cycles of POLL, then 1 → mosi sequence 1,01,0010101,10100101 (18 bits, 72 clks of cs=1). cs low for TCS_CYC. POLL lasts 40+ cycles, then rdy=1 and err=0.
2. mode=2, addr=0x7F, model drives 0x3C → command bits 1,10,1111111. rdata=0x3C and rdata_vld is a single pulse at the return to IDLE. rdy is 0 throughout.
3. mode=0, then mode=3 → 10-bit frames 1001100000 and 1000000000. No POLL state entered.
4. mode=6 → err pulse, cs never rises, rdy stays 1. A start asserted while a READ is in progress is ignored and the READ result is unchanged.
5. rst_n=0 for one cycle at bit 9 of a WRITE → next cycle cs=0, sk=0, rdy=1, no rdata_vld. A new READ afterwards completes correctly.
6. With MW_BUSY_TIMEOUT_EN and BUSY_TO=50, ERASE with miso held 0 → err pulses 50 cycles into POLL, cs=0, rdy=1. Without the macro, rdy stays 0 after 1000 cycles.
